// File: rtl/legv8_pkg.sv
// Shared LEGv8 execute-stage definitions.
//   - R-type opcode constants (instruction[31:21])
//   - Aluop encodings from the main decoder
//   - 4-bit ALU control codes
//   - EX state constants (StMulBusy only reachable when EX_MUL_EN is defined)
//   - EX/MEM pipeline register bundle and a helper that turns it into a bubble
package legv8_pkg;

    localparam logic [10:0] OpcAdd = 11'b10001011000;
    localparam logic [10:0] OpcSub = 11'b11001011000;
    localparam logic [10:0] OpcAnd = 11'b10001010000;
    localparam logic [10:0] OpcOrr = 11'b10101010000;
    localparam logic [10:0] OpcMul = 11'b10011011000;

    localparam logic [1:0] AluopLdSt  = 2'b00;
    localparam logic [1:0] AluopCbz   = 2'b01;
    localparam logic [1:0] AluopRType = 2'b10;

    typedef enum logic [3:0] {
        AluAnd   = 4'b0000,
        AluOrr   = 4'b0001,
        AluAdd   = 4'b0010,
        AluSub   = 4'b0110,
        AluPassB = 4'b0111
    } alu_ctl_e;

    typedef logic [0:0] ex_state_t;
    localparam ex_state_t StIdle    = 1'b0;
    localparam ex_state_t StMulBusy = 1'b1;

    typedef struct packed {
        logic        valid;
        logic [63:0] alu_result;
        logic        zero;
        logic [63:0] branch_target;
        logic [63:0] write_data;
        logic [4:0]  write_reg;
        logic        branch;
        logic        uncond_branch;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic        memtoreg;
    } ex_mem_t;

    // Bubble keeps the data fields (nobody looks at them) and clears every control bit.
    function automatic ex_mem_t ex_mem_bubble(input ex_mem_t e);
        ex_mem_t b;
        b               = e;
        b.valid         = 1'b0;
        b.branch        = 1'b0;
        b.uncond_branch = 1'b0;
        b.memread       = 1'b0;
        b.memwrite      = 1'b0;
        b.regwrite      = 1'b0;
        b.memtoreg      = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/ex_multiplier.sv
// Iterative 64x64 -> 64 (low half) shift-add multiplier, one step per clock.
//   clock, reset_n : clock, asynchronous active-low reset
//   start          : latch op_a/op_b and begin 64 steps (ignored while busy)
//   abort          : drop any multiply in flight, counter back to 0
//   op_a, op_b     : multiplicand, multiplier
//   busy           : a multiply is in progress
//   done           : this edge performs the 64th step; product is valid now
//   product        : accumulator including the current step
module ex_multiplier (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    logic        busy_q;
    logic [5:0]  count_q;
    logic [63:0] mcand_q;
    logic [63:0] mplier_q;
    logic [63:0] acc_q;
    logic [63:0] acc_step;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign busy     = busy_q;
    assign done     = busy_q && (count_q == 6'd63);
    assign product  = acc_step;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (abort) begin
            busy_q  <= 1'b0;
            count_q <= '0;
        end else if (start && !busy_q) begin
            busy_q   <= 1'b1;
            count_q  <= '0;
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 6'd1;
            if (count_q == 6'd63) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// LEGv8 execute stage: ALU control decode, 64-bit ALU, zero flag, branch target,
// and the EX/MEM pipeline register with valid/flush handling.
// Optional feature macro EX_MUL_EN: adds MUL (64-cycle iterative) with ex_stall;
// without it MUL decodes as an unknown R-type (NOP) and ex_stall is tied 0.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   id_valid, flush         : ID/EX holds an instruction / kill capture and multiply
//   Pc, Read1, Read2, Sign_extended, alu_ctrl_data, write_reg, Aluop, ALUSrc,
//   Branch, Uncond_Branch, Memread, Memwrite, RegWrite, MemtoReg : ID/EX bundle
//   ex_stall                : front end must hold IF/ID and ID/EX
//   mem_valid, alu_result, zero, branch_target, write_data, mem_write_reg,
//   mem_* control bits      : EX/MEM register contents
module ex_stage
    import legv8_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic        flush,
    input  logic [63:0] Pc,
    input  logic [63:0] Read1,
    input  logic [63:0] Read2,
    input  logic [63:0] Sign_extended,
    input  logic [10:0] alu_ctrl_data,
    input  logic [4:0]  write_reg,
    input  logic [1:0]  Aluop,
    input  logic        ALUSrc,
    input  logic        Branch,
    input  logic        Uncond_Branch,
    input  logic        Memread,
    input  logic        Memwrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    output logic        ex_stall,
    output logic        mem_valid,
    output logic [63:0] alu_result,
    output logic [63:0] branch_target,
    output logic [63:0] write_data,
    output logic        zero,
    output logic [4:0]  mem_write_reg,
    output logic        mem_branch,
    output logic        mem_uncond_branch,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic        mem_regwrite,
    output logic        mem_memtoreg
);

    alu_ctl_e    alu_ctl;
    logic        op_nop;
    logic [63:0] operand_b;
    logic [63:0] alu_out;
    logic [63:0] issue_result;
    ex_mem_t     issue;
    ex_mem_t     ex_mem_d, ex_mem_q;

    // Aluop 11 is treated like 10 (R-type decode by opcode).
    always_comb begin
        alu_ctl = AluAdd;
        op_nop  = 1'b0;
        unique case (Aluop)
            AluopLdSt: alu_ctl = AluAdd;
            AluopCbz:  alu_ctl = AluPassB;
            default: begin
                unique case (alu_ctrl_data)
                    OpcAdd: alu_ctl = AluAdd;
                    OpcSub: alu_ctl = AluSub;
                    OpcAnd: alu_ctl = AluAnd;
                    OpcOrr: alu_ctl = AluOrr;
`ifdef EX_MUL_EN
                    // Result comes from the multiplier; ALU output is unused.
                    OpcMul: alu_ctl = AluAdd;
`endif
                    default: op_nop = 1'b1;
                endcase
            end
        endcase
    end

    assign operand_b = ALUSrc ? Sign_extended : Read2;

    always_comb begin
        case (alu_ctl)
            AluAnd:  alu_out = Read1 & operand_b;
            AluOrr:  alu_out = Read1 | operand_b;
            AluAdd:  alu_out = Read1 + operand_b;
            AluSub:  alu_out = Read1 - operand_b;
            default: alu_out = operand_b;
        endcase
    end

    assign issue_result = op_nop ? 64'd0 : alu_out;

    // Everything the current ID/EX instruction would write into EX/MEM.
    always_comb begin
        issue               = '0;
        issue.valid         = 1'b1;
        issue.alu_result    = issue_result;
        issue.zero          = (issue_result == 64'd0);
        issue.branch_target = Pc + (Sign_extended << 2);
        issue.write_data    = Read2;
        issue.write_reg     = write_reg;
        issue.branch        = Branch;
        issue.uncond_branch = Uncond_Branch;
        issue.memread       = Memread;
        issue.memwrite      = Memwrite & ~op_nop;
        issue.regwrite      = RegWrite & ~op_nop;
        issue.memtoreg      = MemtoReg;
    end

`ifdef EX_MUL_EN
    ex_state_t   state_d, state_q;
    ex_mem_t     mul_hold_d, mul_hold_q;
    logic        is_mul;
    logic        mul_start;
    logic        mul_busy;
    logic        mul_done;
    logic [63:0] mul_product;

    assign is_mul = Aluop[1] && (alu_ctrl_data == OpcMul);

    ex_multiplier u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (mul_start),
        .abort   (flush),
        .op_a    (Read1),
        .op_b    (Read2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        ex_mem_d   = ex_mem_q;
        state_d    = state_q;
        mul_hold_d = mul_hold_q;
        mul_start  = 1'b0;
        if (state_q == StMulBusy) begin
            // EX/MEM already holds a bubble from the start edge; ID/EX is ignored.
            if (flush) begin
                state_d = StIdle;
            end else if (mul_busy && mul_done) begin
                ex_mem_d            = mul_hold_q;
                ex_mem_d.alu_result = mul_product;
                ex_mem_d.zero       = (mul_product == 64'd0);
                state_d             = StIdle;
            end
        end else if (flush || !id_valid) begin
            ex_mem_d = ex_mem_bubble(ex_mem_q);
        end else if (is_mul) begin
            ex_mem_d   = ex_mem_bubble(ex_mem_q);
            mul_hold_d = issue;
            mul_start  = 1'b1;
            state_d    = StMulBusy;
        end else begin
            ex_mem_d = issue;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            mul_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            mul_hold_q <= mul_hold_d;
        end
    end

    assign ex_stall = (state_q == StMulBusy);
`else
    always_comb begin
        if (flush || !id_valid) begin
            ex_mem_d = ex_mem_bubble(ex_mem_q);
        end else begin
            ex_mem_d = issue;
        end
    end

    assign ex_stall = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign mem_valid         = ex_mem_q.valid;
    assign alu_result        = ex_mem_q.alu_result;
    assign zero              = ex_mem_q.zero;
    assign branch_target     = ex_mem_q.branch_target;
    assign write_data        = ex_mem_q.write_data;
    assign mem_write_reg     = ex_mem_q.write_reg;
    assign mem_branch        = ex_mem_q.branch;
    assign mem_uncond_branch = ex_mem_q.uncond_branch;
    assign mem_memread       = ex_mem_q.memread;
    assign mem_memwrite      = ex_mem_q.memwrite;
    assign mem_regwrite      = ex_mem_q.regwrite;
    assign mem_memtoreg      = ex_mem_q.memtoreg;

endmodule
